// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate controller for the data-cache arrays and the word-serial memory port.
// Define DCACHE_PERF_COUNTERS_EN to add the saturating hit_count_o / miss_count_o outputs.
module data_cache_controller #(
    parameter int CACHE_SIZE = 8192,
    parameter int BLOCK_SIZE = 16,
    localparam int WORDS  = BLOCK_SIZE / 4,
    localparam int INDEX  = $clog2(CACHE_SIZE / BLOCK_SIZE),
    localparam int OFFSET = $clog2(WORDS),
    localparam int TAG    = 30 - INDEX - OFFSET
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cpu_read_i,
    input  logic           cpu_write_i,
    input  logic [31:0]    cpu_address_i,
    input  logic [3:0]     cpu_byte_write_i,
    input  logic [31:0]    cpu_data_i,
    output logic           cpu_ready_o,
    output logic           cpu_done_o,
    output logic [31:0]    cpu_data_o,
    output logic [31:0]    cache_rw_address_o,
    output logic [31:0]    cache_read_address_o,
    // enable vectors are {tag, valid, dirty, data}; cache_read_o[7:4] is port 1; status is {valid, dirty}
    output logic [3:0]     cache_write_o,
    output logic [3:0]     cache_byte_write_o,
    output logic [31:0]    cache_write_data_o,
    output logic [1:0]     cache_status_o,
    output logic [7:0]     cache_read_o,
    input  logic [31:0]    cache_read_data_i,
    input  logic [TAG-1:0] cache_read_tag_i,
    input  logic [1:0]     cache_dirty_i,
    input  logic [1:0]     cache_hit_i,
    output logic [31:0]    mem_address_o,
    output logic           mem_read_o,
    output logic           mem_write_o,
    output logic [31:0]    mem_data_o,
    input  logic [31:0]    mem_data_i,
    input  logic           mem_valid_i,
    input  logic           mem_done_i
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]    hit_count_o,
    output logic [31:0]    miss_count_o
`endif
);

    localparam int EN_DATA  = 0;
    localparam int EN_DIRTY = 1;
    localparam int EN_VALID = 2;
    localparam int EN_TAG   = 3;

    typedef enum logic [2:0] {INIT, IDLE, COMPARE, WB_READ, WB_SEND, ALLOC, REPLAY} state_t;

    state_t            state;
    logic [INDEX-1:0]  init_index;
    logic [OFFSET-1:0] word;
    logic [31:2]       req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_data;
    logic              req_write;
    logic              first_compare;
    logic [TAG-1:0]    victim_tag;
    logic [31:0]       wb_data;
    logic              wb_held;

    logic [TAG-1:0]    req_tag;
    logic [INDEX-1:0]  req_index;
    logic              cpu_req;
    logic              hit;
    logic              last_word;
    logic              unused_ok;

    assign req_tag   = req_addr[31 -: TAG];
    assign req_index = req_addr[2+OFFSET +: INDEX];
    assign cpu_req   = cpu_read_i | cpu_write_i;
    assign hit       = cache_hit_i[1];
    assign last_word = (word == OFFSET'(WORDS - 1));
    assign unused_ok = ^{cpu_address_i[1:0], cache_dirty_i[0], cache_hit_i[0]};

    // The arrays answer one cycle after a read is issued, so array and memory
    // strobes are decoded from the state to meet the one-cycle hit latency.
    always_comb begin
        cpu_ready_o          = 1'b0;
        cpu_done_o           = 1'b0;
        cpu_data_o           = '0;
        cache_rw_address_o   = '0;
        cache_read_address_o = '0;
        cache_write_o        = '0;
        cache_byte_write_o   = '0;
        cache_write_data_o   = '0;
        cache_status_o       = '0;
        cache_read_o         = '0;
        mem_address_o        = '0;
        mem_read_o           = 1'b0;
        mem_write_o          = 1'b0;
        mem_data_o           = '0;
        if (!rst_i) begin
            case (state)
                INIT: begin
                    cache_write_o[EN_VALID] = 1'b1;
                    cache_write_o[EN_DIRTY] = 1'b1;
                    cache_rw_address_o      = {{TAG{1'b0}}, init_index, {OFFSET{1'b0}}, 2'b00};
                end
                IDLE: begin
                    cpu_ready_o = 1'b1;
                    if (cpu_req) begin
                        cache_read_o[7:4]    = 4'hF;
                        cache_read_address_o = {cpu_address_i[31:2], 2'b00};
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        cpu_done_o = 1'b1;
                        if (req_write) begin
                            cache_write_o[EN_DATA]  = 1'b1;
                            cache_write_o[EN_DIRTY] = 1'b1;
                            cache_byte_write_o      = req_be;
                            cache_write_data_o      = req_data;
                            cache_status_o          = 2'b11;
                            cache_rw_address_o      = {req_addr, 2'b00};
                        end else begin
                            cpu_data_o = cache_read_data_i;
                        end
                    end
                end
                WB_READ: begin
                    cache_read_o[4+EN_DATA] = 1'b1;
                    cache_read_address_o    = {victim_tag, req_index, word, 2'b00};
                end
                WB_SEND: begin
                    mem_write_o   = 1'b1;
                    mem_address_o = {victim_tag, req_index, word, 2'b00};
                    mem_data_o    = wb_held ? wb_data : cache_read_data_i;
                end
                ALLOC: begin
                    mem_read_o    = 1'b1;
                    mem_address_o = {req_tag, req_index, word, 2'b00};
                    if (mem_valid_i) begin
                        cache_write_o[EN_DATA] = 1'b1;
                        cache_byte_write_o     = 4'hF;
                        cache_write_data_o     = mem_data_i;
                        cache_rw_address_o     = {req_tag, req_index, word, 2'b00};
                        if (last_word) begin
                            cache_write_o[EN_TAG]   = 1'b1;
                            cache_write_o[EN_VALID] = 1'b1;
                            cache_write_o[EN_DIRTY] = 1'b1;
                            cache_status_o          = 2'b10;
                        end
                    end
                end
                REPLAY: begin
                    cache_read_o[7:4]    = 4'hF;
                    cache_read_address_o = {req_addr, 2'b00};
                end
                default: ;
            endcase
        end
    end

    // The victim word is captured on its first send cycle so the memory sees
    // stable data however long the write acknowledge takes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= INIT;
            init_index    <= '0;
            word          <= '0;
            req_addr      <= '0;
            req_be        <= '0;
            req_data      <= '0;
            req_write     <= 1'b0;
            first_compare <= 1'b0;
            victim_tag    <= '0;
            wb_data       <= '0;
            wb_held       <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_index <= init_index + INDEX'(1);
                    if (init_index == '1) state <= IDLE;
                end
                IDLE: begin
                    if (cpu_req) begin
                        req_addr      <= cpu_address_i[31:2];
                        req_be        <= cpu_byte_write_i;
                        req_data      <= cpu_data_i;
                        req_write     <= cpu_write_i;
                        first_compare <= 1'b1;
                        state         <= COMPARE;
                    end
                end
                COMPARE: begin
                    first_compare <= 1'b0;
                    if (hit) begin
                        state <= IDLE;
                    end else if (cache_dirty_i[1]) begin
                        victim_tag <= cache_read_tag_i;
                        state      <= WB_READ;
                    end else begin
                        state <= ALLOC;
                    end
                end
                WB_READ: begin
                    wb_held <= 1'b0;
                    state   <= WB_SEND;
                end
                WB_SEND: begin
                    if (!wb_held) begin
                        wb_held <= 1'b1;
                        wb_data <= cache_read_data_i;
                    end
                    if (mem_done_i) begin
                        word  <= word + OFFSET'(1);
                        state <= last_word ? ALLOC : WB_READ;
                    end
                end
                ALLOC: begin
                    if (mem_valid_i) begin
                        word <= word + OFFSET'(1);
                        if (last_word) state <= REPLAY;
                    end
                end
                REPLAY: state <= COMPARE;
                default: state <= INIT;
            endcase
        end
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    // Only the first lookup of a request counts; the post-refill replay does not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (state == COMPARE && first_compare) begin
            if (hit) begin
                if (hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
            end else begin
                if (miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: behavioural array block and memory, scoreboard queues for loads and memory traffic.
module tb_data_cache_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_read_i, cpu_write_i;
    logic [31:0] cpu_address_i, cpu_data_i;
    logic [3:0]  cpu_byte_write_i;
    logic        cpu_ready_o, cpu_done_o;
    logic [31:0] cpu_data_o;
    logic [31:0] cache_rw_address_o, cache_read_address_o;
    logic [3:0]  cache_write_o, cache_byte_write_o;
    logic [31:0] cache_write_data_o;
    logic [1:0]  cache_status_o;
    logic [7:0]  cache_read_o;
    logic [31:0] cache_read_data_i;
    logic [18:0] cache_read_tag_i;
    logic [1:0]  cache_dirty_i, cache_hit_i;
    logic [31:0] mem_address_o, mem_data_o, mem_data_i;
    logic        mem_read_o, mem_write_o, mem_valid_i, mem_done_i;
`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count_o, miss_count_o;
`endif

    data_cache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i), .cpu_address_i(cpu_address_i),
        .cpu_byte_write_i(cpu_byte_write_i), .cpu_data_i(cpu_data_i),
        .cpu_ready_o(cpu_ready_o), .cpu_done_o(cpu_done_o), .cpu_data_o(cpu_data_o),
        .cache_rw_address_o(cache_rw_address_o), .cache_read_address_o(cache_read_address_o),
        .cache_write_o(cache_write_o), .cache_byte_write_o(cache_byte_write_o),
        .cache_write_data_o(cache_write_data_o), .cache_status_o(cache_status_o),
        .cache_read_o(cache_read_o), .cache_read_data_i(cache_read_data_i),
        .cache_read_tag_i(cache_read_tag_i), .cache_dirty_i(cache_dirty_i), .cache_hit_i(cache_hit_i),
        .mem_address_o(mem_address_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i),
        .mem_done_i(mem_done_i)
`ifdef DCACHE_PERF_COUNTERS_EN
        , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic is_load; logic [31:0] data; } cpu_exp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_exp_t;

    cpu_exp_t    cpu_q[$];
    logic [31:0] rd_q[$];
    wr_exp_t     wr_q[$];
    logic [31:0] ext_mem [int unsigned];

    int vectors = 0;
    int miscompares = 0;
    int done_count = 0;
    int read_cycles = 0;
    int rd_lat = 0, wr_lat = 0, rd_wait = 0, wr_wait = 0;

    // Array block model: registered read and hit compare, byte-enabled writes.
    logic [31:0] mdl_data [2048];
    logic [18:0] mdl_tag [512];
    logic        mdl_valid [512];
    logic        mdl_dirty [512];
    logic [31:0] mdl_rd_data;
    logic [18:0] mdl_rd_tag;
    logic        mdl_hit, mdl_dirty_out;

    assign cache_read_data_i = mdl_rd_data;
    assign cache_read_tag_i  = mdl_rd_tag;
    assign cache_hit_i       = {mdl_hit, 1'b0};
    assign cache_dirty_i     = {mdl_dirty_out, 1'b0};

    // Garbage valid/dirty/tag is loaded while reset is held so the clear sweep is observable.
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 512; i++) begin
                mdl_valid[i] <= 1'b1;
                mdl_dirty[i] <= 1'b1;
                mdl_tag[i]   <= 19'(i);
            end
        end else begin
            if (|cache_read_o[7:4]) begin
                mdl_rd_data   <= mdl_data[cache_read_address_o[12:2]];
                mdl_rd_tag    <= mdl_tag[cache_read_address_o[12:4]];
                mdl_hit       <= mdl_valid[cache_read_address_o[12:4]] &&
                                 (mdl_tag[cache_read_address_o[12:4]] == cache_read_address_o[31:13]);
                mdl_dirty_out <= mdl_valid[cache_read_address_o[12:4]] && mdl_dirty[cache_read_address_o[12:4]];
            end
            if (cache_write_o[0])
                for (int b = 0; b < 4; b++)
                    if (cache_byte_write_o[b])
                        mdl_data[cache_rw_address_o[12:2]][8*b +: 8] <= cache_write_data_o[8*b +: 8];
            if (cache_write_o[1]) mdl_dirty[cache_rw_address_o[12:4]] <= cache_status_o[0];
            if (cache_write_o[2]) mdl_valid[cache_rw_address_o[12:4]] <= cache_status_o[1];
            if (cache_write_o[3]) mdl_tag[cache_rw_address_o[12:4]]   <= cache_rw_address_o[31:13];
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ext_mem.exists(a)) return ext_mem[a];
        return {a[15:0] ^ 16'h1234, a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Memory responder and scoreboard pops, all on the falling edge.
    always @(negedge clk_i) begin
        if (cpu_done_o) begin
            done_count++;
            checkOutput("done_expected", 32'(cpu_q.size() > 0), 32'd1);
            if (cpu_q.size() > 0) begin
                cpu_exp_t e;
                e = cpu_q.pop_front();
                if (e.is_load) checkOutput("load_data", cpu_data_o, e.data);
            end
        end
        if (mem_read_o) read_cycles++;
        if (mem_valid_i) begin
            mem_valid_i = 1'b0;
        end else if (mem_read_o) begin
            if (rd_wait >= rd_lat) begin
                rd_wait = 0;
                checkOutput("read_expected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) checkOutput("read_addr", mem_address_o, rd_q.pop_front());
                mem_data_i  = mem_word(mem_address_o);
                mem_valid_i = 1'b1;
            end else rd_wait++;
        end else rd_wait = 0;
        if (mem_done_i) begin
            mem_done_i = 1'b0;
        end else if (mem_write_o) begin
            checkOutput("write_expected", 32'(wr_q.size() > 0), 32'd1);
            if (wr_q.size() > 0) begin
                checkOutput("wb_addr", mem_address_o, wr_q[0].addr);
                checkOutput("wb_data", mem_data_o, wr_q[0].data);
                if (wr_wait >= wr_lat) begin
                    wr_wait = 0;
                    ext_mem[mem_address_o] = mem_data_o;
                    void'(wr_q.pop_front());
                    mem_done_i = 1'b1;
                end else wr_wait++;
            end
        end else wr_wait = 0;
    end

    task automatic applyStimulus(input logic is_write, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] data, input logic [31:0] exp_load);
        int n = 0;
        while (!cpu_ready_o && n < 2000) begin @(negedge clk_i); n++; end
        checkOutput("ready_before_request", 32'(cpu_ready_o), 32'd1);
        cpu_q.push_back('{is_load: !is_write, data: exp_load});
        cpu_read_i = !is_write; cpu_write_i = is_write;
        cpu_address_i = addr; cpu_byte_write_i = be; cpu_data_i = data;
        @(posedge clk_i);
        @(negedge clk_i);
        cpu_read_i = 1'b0; cpu_write_i = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        int n = 0;
        while (!cpu_done_o && n < bound) begin @(negedge clk_i); n++; end
        checkOutput("done_seen", 32'(cpu_done_o), 32'd1);
        @(negedge clk_i);
    endtask

    task automatic waitInit();
        int n = 0;
        int cleared = 0;
        while (!cpu_ready_o && n < 2000) begin @(posedge clk_i); #1; n++; end
        checkOutput("init_cycles", n, 32'd512);
        for (int i = 0; i < 512; i++) if (!mdl_valid[i]) cleared++;
        checkOutput("valid_cleared", cleared, 32'd512);
        @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] w;
        int snap, n;
        rst_i = 1'b1; cpu_read_i = 0; cpu_write_i = 0; cpu_address_i = 0;
        cpu_byte_write_i = 0; cpu_data_i = 0; mem_data_i = 0; mem_valid_i = 0; mem_done_i = 0;
        ext_mem[32'h1000] = 32'hDEADBEEF;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_ready", 32'(cpu_ready_o), 32'd0);
        checkOutput("rst_done", 32'(cpu_done_o), 32'd0);
        checkOutput("rst_cpu_data", cpu_data_o, 32'd0);
        checkOutput("rst_mem_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        checkOutput("rst_mem_addr", mem_address_o, 32'd0);
        checkOutput("rst_cache_we", 32'(cache_write_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        waitInit();

        $display("[TB] clean miss on 0x1000");
        for (int k = 0; k < 4; k++) rd_q.push_back(32'h1000 + 32'(4 * k));
        applyStimulus(1'b0, 32'h1000, 4'h0, 32'h0, 32'hDEADBEEF);
        waitDone(100);

        snap = read_cycles;
        applyStimulus(1'b0, 32'h1000, 4'h0, 32'h0, 32'hDEADBEEF);
        checkOutput("load_hit_done_cycle1", 32'(cpu_done_o), 32'd1);
        @(negedge clk_i);
        checkOutput("load_hit_ready_cycle2", 32'(cpu_ready_o), 32'd1);
        checkOutput("hit_no_mem_read", read_cycles, snap);
`ifdef DCACHE_PERF_COUNTERS_EN
        checkOutput("miss_count", miss_count_o, 32'd1);
        checkOutput("hit_count", hit_count_o, 32'd1);
`endif

        $display("[TB] partial store hit on 0x1004");
        applyStimulus(1'b1, 32'h1004, 4'b0011, 32'hAABBCCDD, 32'h0);
        checkOutput("store_hit_done_cycle1", 32'(cpu_done_o), 32'd1);
        @(negedge clk_i);
        w = mem_word(32'h1004);
        applyStimulus(1'b0, 32'h1004, 4'h0, 32'h0, {w[31:16], 16'hCCDD});
        checkOutput("merge_load_done", 32'(cpu_done_o), 32'd1);
        @(negedge clk_i);

        $display("[TB] dirty miss on 0x3004 with slow write acknowledge");
        wr_lat = 5;
        wr_q.push_back('{addr: 32'h1000, data: 32'hDEADBEEF});
        wr_q.push_back('{addr: 32'h1004, data: {w[31:16], 16'hCCDD}});
        wr_q.push_back('{addr: 32'h1008, data: mem_word(32'h1008)});
        wr_q.push_back('{addr: 32'h100C, data: mem_word(32'h100C)});
        for (int k = 0; k < 4; k++) rd_q.push_back(32'h3000 + 32'(4 * k));
        applyStimulus(1'b0, 32'h3004, 4'h0, 32'h0, mem_word(32'h3004));
        waitDone(300);
        checkOutput("wb_queue_drained", wr_q.size(), 32'd0);
        wr_lat = 0;

        $display("[TB] reset during refill word 2");
        rd_lat = 3;
        for (int k = 0; k < 4; k++) rd_q.push_back(32'h5000 + 32'(4 * k));
        applyStimulus(1'b0, 32'h5008, 4'h0, 32'h0, 32'h0);
        void'(cpu_q.pop_back());
        n = 0;
        while (!(mem_read_o && mem_address_o == 32'h5008) && n < 200) begin @(negedge clk_i); n++; end
        checkOutput("alloc_word2_reached", 32'(n < 200), 32'd1);
        snap = done_count;
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("abort_mem_read", 32'(mem_read_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rd_q.delete();
        rd_lat = 0;
        rst_i = 1'b0;
        waitInit();
        checkOutput("abort_no_done", done_count, snap);

        $display("[TB] refill after re-init returns written-back data");
        for (int k = 0; k < 4; k++) rd_q.push_back(32'h1000 + 32'(4 * k));
        applyStimulus(1'b0, 32'h1000, 4'h0, 32'h0, 32'hDEADBEEF);
        waitDone(100);
        checkOutput("cpu_queue_drained", cpu_q.size(), 32'd0);
        checkOutput("read_queue_drained", rd_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_cache_controller.md
# data_cache_controller

Direct-mapped, write-back, write-allocate control unit for the data-cache storage arrays. It sits between the CPU load/store unit and the cache array block (data, tag, valid and dirty memories with registered hit compare), and drives every enable, address and status input of that block. It also runs the word-serial refill and write-back transfers to the external memory port, and clears the valid and dirty arrays after reset.

## Interface
- CACHE_SIZE, 8192: total cache bytes; must match the array block.
- BLOCK_SIZE, 16: bytes per block; WORDS = BLOCK_SIZE/4; INDEX = log2(CACHE_SIZE/BLOCK_SIZE); OFFSET = log2(WORDS); TAG = 30-INDEX-OFFSET (local).
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_read_i / cpu_write_i  in  1  request strobes, sampled only while cpu_ready_o=1; both high → write wins.
- cpu_address_i  in  32  byte address; bits [1:0] ignored.
- cpu_byte_write_i  in  4  store byte enables.
- cpu_data_i  in  32  store data.
- cpu_ready_o  out  1  controller idle, accepts a request.
- cpu_done_o  out  1  one-cycle completion pulse.
- cpu_data_o  out  32  load data, valid with cpu_done_o.
- cache_rw_address_o, cache_read_address_o  out  32  array write and read addresses.
- cache_write_o  out  data_enable_t  data/dirty/valid/tag write enables.
- cache_byte_write_o  out  4; cache_write_data_o  out  32; cache_status_o  out  status_packet_t.
- cache_read_o  out  data_enable_t[1:0]  read enables. Port 0 is tied 0.
- cache_read_data_i  in  32; cache_read_tag_i  in  TAG; cache_dirty_i, cache_hit_i  in  2  array outputs. Only index 1 is used.
- mem_address_o  out  32; mem_read_o, mem_write_o  out  1; mem_data_o  out  32.
- mem_data_i  in  32; mem_valid_i  in  1  refill word valid; mem_done_i  in  1  write word accepted.

## Operation
- FSM states: INIT, IDLE, COMPARE, WB_READ, WB_SEND, ALLOC, REPLAY.
- **INIT** (entered on reset)
  - Index counter runs 0 → 2^INDEX-1, one index per cycle.
  - Each cycle writes valid=0 and dirty=0.
  - Exits to IDLE after the last index.
- **IDLE**
  - cpu_ready_o=1.
  - On a strobe: latch address, byte enables, data and op.
  - Issue an array read on port 1 with all fields at cpu_address_i.
  - Go to COMPARE.
- **COMPARE** (array outputs valid this cycle)
  - Load hit: cpu_data_o=cache_read_data_i, pulse cpu_done_o, go to IDLE.
  - Store hit: write data with byte enables, write dirty=1, pulse cpu_done_o, go to IDLE.
  - Miss with dirty_i[1]=1: latch the victim tag, go to WB_READ.
  - Miss with dirty_i[1]=0: go to ALLOC.
- **WB_READ**
  - Read data word k of the victim index.
  - Go to WB_SEND.
- **WB_SEND**
  - Drive mem_write_o=1, mem_address_o={victim tag, index, k, 2'b00}, mem_data_o = the read word.
  - Hold all three until mem_done_i.
  - Then k++ and go back to WB_READ, or go to ALLOC after word WORDS-1.
- **ALLOC**
  - Drive mem_read_o=1, mem_address_o={request tag, index, k, 2'b00}.
  - On mem_valid_i: write word k with byte enables 4'hF, then k++.
  - The write of the last word also writes tag, valid=1 and dirty=0, then goes to REPLAY.
- **REPLAY**
  - Reissue the port-1 read at the latched address.
  - Go to COMPARE, which now hits.
- The word counter k is OFFSET bits wide and wraps to 0 on leaving WB_SEND and ALLOC.
- All 32-bit addresses are formed by concatenation; there is no arithmetic carry.

## Timing
- Reset values:
  - cpu_ready_o=0, cpu_done_o=0, cpu_data_o=0.
  - mem_read_o=0, mem_write_o=0, mem_address_o=0, mem_data_o=0.
  - All cache enables and addresses are 0, except INIT's writes, which start on the first cycle after reset deasserts.
- INIT lasts 2^INDEX cycles; cpu_ready_o rises on the cycle after the final clear.
- Hit latency: request accepted in cycle 0, cpu_done_o in cycle 1, cpu_ready_o again in cycle 2.
- Clean miss latency: 2 + (memory cycles for WORDS words) + 2 cycles.
- Dirty miss: adds WORDS × (1 + memory write-accept cycles).
- Reset asserted mid-operation:
  - Aborts immediately; mem strobes drop on the next edge.
  - The pending CPU request is dropped with no cpu_done_o.
  - INIT restarts.
- mem_valid_i or mem_done_i arriving outside ALLOC / WB_SEND is ignored.

## Configuration
- DCACHE_PERF_COUNTERS_EN defined:
  - Adds outputs hit_count_o[31:0] and miss_count_o[31:0].
  - Each increments once per first COMPARE of a request; REPLAY hits are not counted.
  - Both saturate at 32'hFFFFFFFF and clear on rst_i.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset held 3 cycles then released, defaults → cpu_ready_o low for exactly 512 cycles; every index reads valid=0.
- Load 0x0000_1000 after INIT (memory word 0xDEADBEEF) → clean miss:
  - four mem reads at 0x1000–0x100C;
  - cpu_done_o with cpu_data_o=0xDEADBEEF;
  - a repeat load completes in 2 cycles with no mem_read_o.
- Store 0xAABBCCDD, bytes 4'b0011, to 0x1004 after the above → hit, done in cycle 1; a following load of 0x1004 returns 0x????CCDD with the upper half unchanged.
- Load 0x0000_3004 (same index, different tag) after the dirty store → four mem writes at 0x1000–0x100C, word 1 carrying the stored value, then four reads at 0x3000–0x300C.
- mem_done_i delayed 5 cycles per word → mem_write_o and mem_data_o held stable for the whole wait.
- rst_i pulsed during ALLOC word 2 → mem_read_o low the next cycle, no cpu_done_o, INIT reruns.
- With DCACHE_PERF_COUNTERS_EN: miss, then hit → miss_count_o=1, hit_count_o=1.
